// File: rtl/line_stream_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : line_stream_writer_if                                           |
// | Purpose  : AXI-Stream beat bundle carrying one raster line per packet.     |
// |            tdata[DATA_W-1] is the lowest x of the beat; tuser marks the    |
// |            first beat of row 0; tlast marks the end of a line.            |
// | Ports    : tdata, tkeep, tlast, tuser, tvalid (source -> sink)             |
// |            tready (sink -> source)                                         |
// | Modports : master (stream source), slave (stream sink)                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface line_stream_writer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tuser;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/line_stream_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : line_stream_writer                                              |
// | Purpose  : Receives a 1-bit-per-cell raster over AXI-Stream, rebuilds each |
// |            X_SIZE-bit line word and writes it to the line BRAM at its row. |
// |            Bit X_SIZE-1 of a line word is x 0.                             |
// | Ports    : aclk, aresetn (async, active low)                               |
// |            in_stream  - stream sink (slave modport)                        |
// |            bram_addr/bram_din/bram_we - BRAM write port, held between      |
// |            writes                                                          |
// |            frame_done, err_eol, err_sof - registered one-cycle pulses      |
// |            frame_count, err_count - only with LINE_WRITER_FRAME_COUNT_EN   |
// | Options  : `define LINE_WRITER_FRAME_COUNT_EN adds the frame/error counters|
// | Notes    : X_SIZE must be a multiple of DATA_W with at least two beats per |
// |            line, and Y_SIZE must be at least 2.                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module line_stream_writer #(
  parameter int X_SIZE = 1280,
  parameter int Y_SIZE = 720,
  parameter int DATA_W = 32
) (
  input  wire                       aclk,
  input  wire                       aresetn,
  line_stream_writer_if.slave       in_stream,
  output logic [$clog2(Y_SIZE)-1:0] bram_addr,
  output logic [X_SIZE-1:0]         bram_din,
  output logic                      bram_we,
  output logic                      frame_done,
  output logic                      err_eol,
  output logic                      err_sof
`ifdef LINE_WRITER_FRAME_COUNT_EN
  ,
  output logic [15:0]               frame_count,
  output logic [15:0]               err_count
`endif
);

  localparam int c_BEATS  = X_SIZE / DATA_W;
  localparam int CNT_W    = $clog2(c_BEATS);
  localparam int ADDR_W   = $clog2(Y_SIZE);
  localparam logic [CNT_W-1:0]  c_LAST_BEAT = CNT_W'(c_BEATS - 1);
  localparam logic [ADDR_W-1:0] c_LAST_ROW  = ADDR_W'(Y_SIZE - 1);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_row, w_row_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [X_SIZE-1:0]   r_line, w_line_nxt;
  logic                r_ready_en;
  logic                r_we, w_we_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [X_SIZE-1:0]   r_din;
  logic                r_done, w_done_nxt;
  logic                r_err_eol, w_eol_nxt;
  logic                r_err_sof, w_sof_nxt;

  logic                w_accept;
  logic [X_SIZE-1:0]   w_shift;
  logic                w_unused_tkeep;

  // tkeep carries no information for this raster format
  assign w_unused_tkeep = ^in_stream.tkeep;

  // r_ready_en keeps tready low through reset and the cycle it is released
  assign in_stream.tready = r_ready_en && (r_state != ST_WRITE);
  assign w_accept         = in_stream.tvalid && in_stream.tready;
  // Earlier beats move toward the MSB so beat 0 ends up holding x 0
  assign w_shift          = {r_line[X_SIZE-DATA_W-1:0], in_stream.tdata};

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_line_nxt  = r_line;
    w_we_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_eol_nxt   = 1'b0;
    w_sof_nxt   = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_accept && in_stream.tuser) begin
          if (in_stream.tlast) begin
            w_eol_nxt = 1'b1;
          end else begin
            w_line_nxt  = w_shift;
            w_row_nxt   = '0;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (w_accept) begin
          if (in_stream.tuser && (r_cnt != '0 || r_row != '0)) begin
            // Misplaced start of frame: restart at row 0 using this beat;
            // any tlast on it is not reported since err_sof wins.
            w_sof_nxt  = 1'b1;
            w_line_nxt = w_shift;
            w_row_nxt  = '0;
            w_cnt_nxt  = CNT_W'(1);
          end else if (!in_stream.tuser && r_cnt == '0 && r_row == '0) begin
            w_sof_nxt   = 1'b1;
            w_state_nxt = ST_SYNC;
          end else if (r_cnt == c_LAST_BEAT) begin
            if (in_stream.tlast) begin
              w_line_nxt  = w_shift;
              w_we_nxt    = 1'b1;
              w_done_nxt  = (r_row == c_LAST_ROW);
              w_state_nxt = ST_WRITE;
            end else begin
              w_eol_nxt   = 1'b1;
              w_state_nxt = ST_SYNC;
            end
          end else if (in_stream.tlast) begin
            // Short line: drop it and expect the same row again
            w_eol_nxt = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_line_nxt = w_shift;
            w_cnt_nxt  = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_WRITE: begin
        // The write strobe is already on the port during this cycle
        w_cnt_nxt   = '0;
        w_row_nxt   = (r_row == c_LAST_ROW) ? '0 : r_row + ADDR_W'(1);
        w_state_nxt = ST_RECV;
      end
      default: begin
        w_state_nxt = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_SYNC;
      r_row      <= '0;
      r_cnt      <= '0;
      r_line     <= '0;
      r_ready_en <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_done     <= 1'b0;
      r_err_eol  <= 1'b0;
      r_err_sof  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_row      <= w_row_nxt;
      r_cnt      <= w_cnt_nxt;
      r_line     <= w_line_nxt;
      r_ready_en <= 1'b1;
      r_we       <= w_we_nxt;
      r_done     <= w_done_nxt;
      r_err_eol  <= w_eol_nxt;
      r_err_sof  <= w_sof_nxt;
      if (w_we_nxt) begin
        r_addr <= r_row;
        r_din  <= w_shift;
      end
    end
  end

  assign bram_addr  = r_addr;
  assign bram_din   = r_din;
  assign bram_we    = r_we;
  assign frame_done = r_done;
  assign err_eol    = r_err_eol;
  assign err_sof    = r_err_sof;

`ifdef LINE_WRITER_FRAME_COUNT_EN
  logic [15:0] r_frame_count;
  logic [15:0] r_err_count;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_count <= '0;
      r_err_count   <= '0;
    end else begin
      if (w_done_nxt) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      if ((w_eol_nxt || w_sof_nxt) && r_err_count != 16'hFFFF) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign frame_count = r_frame_count;
  assign err_count   = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_stream_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_line_stream_writer                                           |
// | Purpose  : Self-checking bench for line_stream_writer. A scoreboard queue  |
// |            holds the expected BRAM writes; a table of line shapes covers   |
// |            the error corner cases.                                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_line_stream_writer;
  localparam int X_SIZE = 1280;
  localparam int Y_SIZE = 720;
  localparam int DATA_W = 32;
  localparam int BEATS  = X_SIZE / DATA_W;
  localparam int ADDR_W = 10;
  localparam int NVEC   = 15;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  line_stream_writer_if #(.DATA_W(DATA_W)) s ();

  logic [ADDR_W-1:0] bram_addr;
  logic [X_SIZE-1:0] bram_din;
  logic              bram_we;
  logic              frame_done;
  logic              err_eol;
  logic              err_sof;
`ifdef LINE_WRITER_FRAME_COUNT_EN
  logic [15:0]       frame_count;
  logic [15:0]       err_count;
`endif

  line_stream_writer #(
    .X_SIZE(X_SIZE),
    .Y_SIZE(Y_SIZE),
    .DATA_W(DATA_W)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .in_stream  (s),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_we    (bram_we),
    .frame_done (frame_done),
    .err_eol    (err_eol),
    .err_sof    (err_sof)
`ifdef LINE_WRITER_FRAME_COUNT_EN
    ,
    .frame_count(frame_count),
    .err_count  (err_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_din(input string name, input logic [X_SIZE-1:0] act, input logic [X_SIZE-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hi %h lo %h, required hi %h lo %h",
               name, act[X_SIZE-1 -: 32], act[63:0], exp[X_SIZE-1 -: 32], exp[63:0]);
    end
  endtask

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [X_SIZE-1:0] din;
    logic              done;
  } wr_t;

  wr_t               exp_q[$];
  wr_t               e_cur;
  int                obs_we   = 0;
  int                obs_eol  = 0;
  int                obs_sof  = 0;
  int                obs_done = 0;
  int                rdy_low  = 0;
  bit                win      = 1'b0;
  bit                cap5     = 1'b0;
  logic [X_SIZE-1:0] row5_din = '0;

  always @(negedge aclk) begin
    if (err_eol) obs_eol++;
    if (err_sof) obs_sof++;
    if (frame_done) begin
      obs_done++;
      chk("done_with_we", bram_we, 1'b1);
    end
    if (win && aresetn && !s.tready) rdy_low++;
    if (bram_we) begin
      obs_we++;
      if (cap5 && bram_addr == ADDR_W'(5)) row5_din = bram_din;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d, required no write", bram_addr);
      end else begin
        e_cur = exp_q.pop_front();
        chk("wr_addr", bram_addr, e_cur.addr);
        chk_din("wr_din", bram_din, e_cur.din);
        chk("wr_frame_done", frame_done, e_cur.done);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] hist[$];
  bit                bp_en = 1'b0;
  logic [7:0]        salt  = 8'h00;

  function automatic logic [DATA_W-1:0] pat(input int tag, input int b, input logic [7:0] sl);
    return {8'h80 ^ 8'(b), sl, 16'(tag)};
  endfunction

  // Line word made of the last BEATS accepted words, first one at the MSB end
  function automatic logic [X_SIZE-1:0] hist_line();
    logic [X_SIZE-1:0] l;
    l = '0;
    for (int b = 0; b < BEATS; b++) l[X_SIZE-1-DATA_W*b -: DATA_W] = hist[hist.size()-BEATS+b];
    return l;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic u, input logic l);
    int guard;
    guard = 0;
    if (bp_en) begin
      while ($urandom_range(0, 2) == 0) begin
        s.tvalid = 1'b0;
        @(posedge aclk);
        #1;
      end
    end
    s.tdata  = d;
    s.tuser  = u;
    s.tlast  = l;
    s.tkeep  = '1;
    s.tvalid = 1'b1;
    while (!s.tready && guard < 20) begin
      @(posedge aclk);
      #1;
      guard++;
    end
    if (!s.tready) begin
      n_checks++;
      n_fail++;
      $display("FAIL tready_timeout: got tready 0 for %0d cycles, required 1", guard);
    end
    @(posedge aclk);
    #1;
    s.tvalid = 1'b0;
  endtask

  // Sends nb beats; ub/lb are the beat indices carrying tuser/tlast (-1 = none)
  task automatic send_line(input int nb, input int ub, input int lb, input int tag,
                           input bit wr, input int addr, input bit done, input bit use_n);
    logic [DATA_W-1:0] d;
    wr_t               e;
    salt = salt + 8'd1;
    for (int b = 0; b < nb; b++) begin
      d = use_n ? DATA_W'(tag) : pat(tag, b, salt);
      hist.push_back(d);
      if (hist.size() > BEATS) void'(hist.pop_front());
      if (wr && b == nb - 1) begin
        e.addr = ADDR_W'(addr);
        e.din  = hist_line();
        e.done = done;
        exp_q.push_back(e);
      end
      send_beat(d, (b == ub), (b == lb));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_tready"}, s.tready, 1'b0);
    chk({tag, "_we"}, bram_we, 1'b0);
    chk({tag, "_addr"}, bram_addr, '0);
    chk_din({tag, "_din"}, bram_din, '0);
    chk({tag, "_pulses"}, {frame_done, err_eol, err_sof}, 3'b000);
  endtask

  typedef struct {
    int reps;
    int nb;
    int ub;
    int lb;
    bit wr;
    int addr;
    int eol;
    int sof;
  } vec_t;

  vec_t tbl[NVEC];

  initial begin
    int w0;
    int tbl_errs;
    s.tdata  = '0;
    s.tkeep  = '0;
    s.tlast  = 1'b0;
    s.tuser  = 1'b0;
    s.tvalid = 1'b0;

    // {reps, beats, tuser beat, tlast beat, write, first addr, err_eol, err_sof}
    tbl[0]  = '{1, 40,  0, 39, 1'b1, 0, 0, 0};  // start of frame
    tbl[1]  = '{2, 40, -1, 39, 1'b1, 1, 0, 0};
    tbl[2]  = '{1, 21, -1, 20, 1'b0, 0, 1, 0};  // row 3 early tlast
    tbl[3]  = '{7, 40, -1, 39, 1'b1, 3, 0, 0};  // row 3 retried, rows up to 9
    tbl[4]  = '{1, 40, -1, -1, 1'b0, 0, 1, 0};  // row 10 missing tlast
    tbl[5]  = '{1,  5, -1, -1, 1'b0, 0, 0, 0};  // discarded while syncing
    tbl[6]  = '{1, 40,  0, 39, 1'b1, 0, 0, 0};  // resync
    tbl[7]  = '{1, 13, 12, -1, 1'b0, 0, 0, 1};  // tuser on beat 12 of row 1
    tbl[8]  = '{1, 39, -1, 38, 1'b1, 0, 0, 0};  // completes the restarted row 0
    tbl[9]  = '{1, 40, -1, 39, 1'b1, 1, 0, 0};
    tbl[10] = '{1,  6,  0, -1, 1'b0, 0, 0, 1};  // tuser on beat 0 of row 2
    tbl[11] = '{1,  5, -1,  4, 1'b0, 0, 1, 0};  // early tlast inside row 0
    tbl[12] = '{1,  1, -1, -1, 1'b0, 0, 0, 1};  // row 0 beat 0 without tuser
    tbl[13] = '{1,  3, -1, -1, 1'b0, 0, 0, 0};  // discarded while syncing
    tbl[14] = '{1, 40,  0, 39, 1'b1, 0, 0, 0};

    // Reset state
    idle(3);
    check_outputs_zero("reset");
    aresetn = 1'b1;
    idle(1);
    chk("tready_after_reset", s.tready, 1'b1);

    // Garbage before sync, then one clean frame with beats = line number
    for (int i = 0; i < 17; i++) send_beat(pat(9999, i, 8'hEE), 1'b0, 1'b0);
    idle(2);
    chk("garbage_writes", obs_we, 0);
    chk("garbage_errors", obs_eol + obs_sof, 0);
    win  = 1'b1;
    cap5 = 1'b1;
    for (int n = 0; n < Y_SIZE; n++)
      send_line(BEATS, (n == 0) ? 0 : -1, BEATS - 1, n, 1'b1, n, (n == Y_SIZE - 1), 1'b1);
    idle(3);
    win  = 1'b0;
    cap5 = 1'b0;
    chk("clean_writes", obs_we, Y_SIZE);
    chk("clean_frame_done", obs_done, 1);
    chk("clean_tready_low", rdy_low, Y_SIZE);
    chk("clean_errors", obs_eol + obs_sof, 0);
    chk("row5_low_word", row5_din[31:0], 32'h5);
    chk("row5_x0_bit", row5_din[X_SIZE-1], 1'b0);

    // Table of line shapes for the error corner cases
    tbl_errs = 0;
    for (int i = 0; i < NVEC; i++) begin
      automatic int e0 = obs_eol;
      automatic int s0 = obs_sof;
      w0 = obs_we;
      for (int r = 0; r < tbl[i].reps; r++)
        send_line(tbl[i].nb, tbl[i].ub, tbl[i].lb, 100 * i + r, tbl[i].wr, tbl[i].addr + r, 1'b0, 1'b0);
      idle(3);
      chk($sformatf("vec%0d_err_eol", i), obs_eol - e0, tbl[i].eol);
      chk($sformatf("vec%0d_err_sof", i), obs_sof - s0, tbl[i].sof);
      chk($sformatf("vec%0d_writes", i), obs_we - w0, tbl[i].wr ? tbl[i].reps : 0);
      tbl_errs += tbl[i].eol + tbl[i].sof;
    end
    chk("table_queue_drained", exp_q.size(), 0);
`ifdef LINE_WRITER_FRAME_COUNT_EN
    chk("frame_count", frame_count, 1);
    chk("err_count", err_count, tbl_errs);
`endif

    // Random backpressure, then reset in the middle of row 100
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    idle(2);
    aresetn = 1'b1;
    hist.delete();
    bp_en = 1'b1;
    for (int n = 0; n < 100; n++)
      send_line(BEATS, (n == 0) ? 0 : -1, BEATS - 1, n, 1'b1, n, 1'b0, 1'b1);
    send_line(25, -1, -1, 100, 1'b0, 0, 1'b0, 1'b1);
    bp_en = 1'b0;
    idle(2);
    chk("bp_queue_drained", exp_q.size(), 0);
    w0 = obs_we;
    s.tdata  = 32'd100;
    s.tvalid = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    check_outputs_zero("midline_reset");
`ifdef LINE_WRITER_FRAME_COUNT_EN
    chk("frame_count_reset", frame_count, 0);
`endif
    s.tvalid = 1'b0;
    idle(3);
    aresetn = 1'b1;
    hist.delete();
    send_line(BEATS, -1, BEATS - 1, 300, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
    chk("post_reset_no_write", obs_we - w0, 0);
    send_line(BEATS, 0, BEATS - 1, 301, 1'b1, 0, 1'b0, 1'b0);
    idle(3);
    chk("post_reset_resync_write", obs_we - w0, 1);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got no end of test by 2 ms, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/line_stream_writer.md
Name: line_stream_writer

Overview:
- AXI-Stream receiver that turns an incoming 1-bit-per-cell raster stream back into full-width line words.
- Writes each line into the line BRAM port at its row address.
- It is the writer feeding the line RAMs that the pixel generator reads from (MSB = x 0).
- It sits between the PS/DMA stream source and the BRAM write port.

Parameters:
X_SIZE, 1280, cells per line (line word width); must be a multiple of DATA_W
Y_SIZE, 720, lines per frame
DATA_W, 32, stream data width; BEATS = X_SIZE/DATA_W (40 by default)

Ports:
aclk  in  1  single clock for stream and BRAM port
aresetn  in  1  asynchronous active-low reset
in_stream_tdata  in  DATA_W  32 cells per beat; tdata[DATA_W-1] is the lowest x of the beat
in_stream_tkeep  in  DATA_W/8  ignored
in_stream_tlast  in  1  end of line
in_stream_tuser  in  1  start of frame (first beat of row 0)
in_stream_tvalid  in  1  beat valid
in_stream_tready  out  1  beat accepted when tvalid&tready
bram_addr  out  clog2(Y_SIZE)  row address
bram_din  out  X_SIZE  assembled line; bit X_SIZE-1 = x 0
bram_we  out  1  one-cycle write strobe
frame_done  out  1  one-cycle pulse after the last row write
err_eol  out  1  one-cycle pulse on tlast early or missing
err_sof  out  1  one-cycle pulse on tuser misplaced or missing

Behaviour:
- Reset (async assert, sync deassert use):
  - state=SYNC; row=0, beat_cnt=0, line reg=0.
  - tready=0, bram_we=0, bram_addr=0, bram_din=0, all pulses 0.
  - tready rises the first cycle after reset release.
- Beat accept: tvalid&tready only. tready=1 in SYNC and RECV, 0 in WRITE.
- Line assembly: line <= {line[X_SIZE-DATA_W-1:0], tdata}, so beat 0 lands in the top DATA_W bits.
- SYNC:
  - Discard accepted beats until one has tuser=1.
  - That beat is shifted in as beat 0 of row 0; beat_cnt=1; go to RECV.
  - tlast on the tuser beat with BEATS>1 -> err_eol; stay in SYNC.
- RECV, per accepted beat:
  - tuser=1 and (beat_cnt!=0 or row!=0): pulse err_sof. Treat the beat as beat 0 of row 0 (resync): row=0, beat_cnt=1.
  - beat_cnt==0, row==0, tuser=0: pulse err_sof, drop beat, go to SYNC.
  - tlast=1 and beat_cnt<BEATS-1: pulse err_eol, discard the partial line, beat_cnt=0, row unchanged, stay in RECV.
  - beat_cnt==BEATS-1 and tlast=0: pulse err_eol, discard line, go to SYNC.
  - beat_cnt==BEATS-1 and tlast=1: shift in, go to WRITE.
  - Otherwise beat_cnt++.
- WRITE (exactly 1 cycle):
  - bram_we=1, bram_addr=row, bram_din=line; beat_cnt=0.
  - row<Y_SIZE-1: row++.
  - row==Y_SIZE-1: row=0, frame_done=1 in the same cycle as bram_we.
  - Return to RECV.
- Latency: bram_we asserts on the cycle after the tlast beat is accepted.
- Throughput: one bubble per line (BEATS+1 cycles per line).
- bram_addr and bram_din hold their values between writes.
- Error pulses and frame_done are registered, one cycle wide. Simultaneous conditions: err_sof takes priority and err_eol is suppressed.
- Reset mid-line: partial line is lost, no write issued, state=SYNC.

Optional Feature:
LINE_WRITER_FRAME_COUNT_EN
- Defined:
  - Adds output frame_count[15:0]: increments with frame_done, wraps 0xFFFF->0, reset 0.
  - Adds output err_count[15:0]: increments on any err_sof|err_eol cycle, saturates at 0xFFFF, reset 0.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Clean frame: 720 lines x 40 beats, tuser on first beat, tlast on every 40th beat, tvalid always high, line n beats = 32'h0000_0000 + n. Required:
  - 720 bram_we pulses with addr 0..719.
  - Row 5 din low word = 32'h5, and bit 1279 = bit 31 of beat 0.
  - frame_done once, coincident with the addr 719 write.
  - tready low exactly one cycle per line.
- Pre-sync garbage: 17 beats without tuser, then a clean frame -> 17 beats discarded, no bram_we, first write at addr 0, no error pulses.
- Early tlast: row 3 gets tlast on beat 20 -> err_eol pulse, no write for that row. Next 40-beat line writes to addr 3.
- Missing tlast: row 10 beat 39 has tlast=0 -> err_eol, no write, state SYNC. Subsequent non-tuser beats are discarded until the next tuser.
- Misplaced tuser: tuser asserted on beat 12 of row 200 -> err_sof. That beat starts row 0, and the next completed line writes to addr 0.
- Random backpressure and reset: tvalid toggled randomly gives identical BRAM contents to the clean run. Asserting aresetn low on beat 25 of row 100 gives all outputs 0 immediately, no write, and resync on the next tuser. With LINE_WRITER_FRAME_COUNT_EN: 3 clean frames -> frame_count=3, err_count=0.
